// File: rtl/cond_pkg.sv
// Shared types for predicated-execution logic: ARM condition codes, NZCV bit
// positions and the condition unit's run/shadow states.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: instruction condition field against NZCV.
// Zero latency, no state; shared by any stage that needs predication.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondPass
);

  logic n, z, c, v;

  assign n = Flags[N_IDX];
  assign z = Flags[Z_IDX];
  assign c = Flags[C_IDX];
  assign v = Flags[V_IDX];

  always_comb begin
    CondPass = 1'b0;
    case (cond_e'(Cond))
      EQ: CondPass = z;
      NE: CondPass = ~z;
      CS: CondPass = c;
      CC: CondPass = ~c;
      MI: CondPass = n;
      PL: CondPass = ~n;
      VS: CondPass = v;
      VC: CondPass = ~v;
      HI: CondPass = c & ~z;
      LS: CondPass = ~c | z;
      GE: CondPass = (n == v);
      LT: CondPass = (n != v);
      GT: CondPass = ~z & (n == v);
      LE: CondPass = z | (n != v);
      AL: CondPass = 1'b1;
      NV: CondPass = 1'b0;
      default: CondPass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV register, condition gating of write strobes,
// and a post-branch squash window. COND_UNIT_PERF_EN adds exec/squash counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int BRANCH_SHADOW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid,
  input  logic        Flush,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic [3:0]  Flags,
  output logic        InShadow
`ifdef COND_UNIT_PERF_EN
  ,
  input  logic        CountClr,
  output logic [31:0] ExecCount,
  output logic [31:0] SquashCount
`endif
);

  localparam logic [2:0] SHADOW_LEN = 3'(BRANCH_SHADOW);

  state_e     state;
  logic [2:0] cnt;
  logic       cond_pass;
  logic       live;

  cond_check u_cond_check (
    .Cond     (Cond),
    .Flags    (Flags),
    .CondPass (cond_pass)
  );

  assign InShadow = (state == SHADOW);
  assign live     = Valid & ~Flush & ~InShadow;
  assign CondEx   = live & cond_pass;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;

  // Condition of the current instruction sees the pre-update flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (CondEx) begin
      if (FlagW[1]) begin
        Flags[N_IDX] <= ALUFlags[N_IDX];
        Flags[Z_IDX] <= ALUFlags[Z_IDX];
      end
      if (FlagW[0]) begin
        Flags[C_IDX] <= ALUFlags[C_IDX];
        Flags[V_IDX] <= ALUFlags[V_IDX];
      end
    end
  end

  // Shadow counts cycles, not instructions, so bubbles still drain the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (PCSrc && (SHADOW_LEN != 3'd0)) begin
            state <= SHADOW;
            cnt   <= SHADOW_LEN;
          end
        end
        SHADOW: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef COND_UNIT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || CountClr) begin
      ExecCount   <= 32'd0;
      SquashCount <= 32'd0;
    end else begin
      if (CondEx) begin
        ExecCount <= ExecCount + 32'd1;
      end
      if (Valid && !CondEx) begin
        SquashCount <= SquashCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed vectors, a per-cycle reference model and
// hand-computed spot checks; counter checks when COND_UNIT_PERF_EN is defined.
module tb_cond_unit;

  localparam int BS = 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       Valid    = 1'b0;
  logic       Flush    = 1'b0;
  logic [3:0] Cond     = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic [1:0] FlagW    = 2'b00;
  logic       PCS      = 1'b0;
  logic       RegW     = 1'b0;
  logic       MemW     = 1'b0;
  logic       PCSrc, RegWrite, MemWrite, CondEx, InShadow;
  logic [3:0] Flags;
  logic       clr_req  = 1'b0;
`ifdef COND_UNIT_PERF_EN
  logic        CountClr = 1'b0;
  logic [31:0] ExecCount, SquashCount;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cond_unit #(.BRANCH_SHADOW(BS)) dut (
    .clk      (clk),
    .reset    (reset),
    .Valid    (Valid),
    .Flush    (Flush),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags),
    .InShadow (InShadow)
`ifdef COND_UNIT_PERF_EN
    ,
    .CountClr    (CountClr),
    .ExecCount   (ExecCount),
    .SquashCount (SquashCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural condition rules, written directly from the ARM definitions.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model state; initial values equal the post-reset state.
  logic [3:0]  m_flags = 4'h0;
  int          m_left  = 0;
  logic [31:0] m_exec  = 32'd0;
  logic [31:0] m_sq    = 32'd0;

  always @(negedge clk) begin
    bit shadow, ex;
    shadow = (m_left > 0);
    ex     = Valid && !Flush && !shadow && cond_ok(Cond, m_flags);
    check("m_CondEx",   CondEx,   ex);
    check("m_PCSrc",    PCSrc,    ex && PCS);
    check("m_RegWrite", RegWrite, ex && RegW);
    check("m_MemWrite", MemWrite, ex && MemW);
    check("m_Flags",    Flags,    m_flags);
    check("m_InShadow", InShadow, shadow);
`ifdef COND_UNIT_PERF_EN
    check("m_ExecCount",   ExecCount,   m_exec);
    check("m_SquashCount", SquashCount, m_sq);
`endif
    if (reset) begin
      m_flags = 4'h0;
      m_left  = 0;
    end else begin
      if (shadow) m_left = m_left - 1;
      else if (ex && PCS && BS > 0) m_left = BS;
      if (ex && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (ex && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
    end
    if (reset || clr_req) begin
      m_exec = 32'd0;
      m_sq   = 32'd0;
    end else begin
      if (ex) m_exec = m_exec + 32'd1;
      if (Valid && !ex) m_sq = m_sq + 32'd1;
    end
  end

  // Apply one cycle of inputs just after the rising edge; return mid-cycle.
  task automatic drive(input bit rst, input bit v, input bit fl, input logic [3:0] c,
                       input logic [3:0] a, input logic [1:0] fw,
                       input bit pcs, input bit rw, input bit mw);
    @(posedge clk);
    #1;
    reset = rst; Valid = v; Flush = fl; Cond = c; ALUFlags = a;
    FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
`ifdef COND_UNIT_PERF_EN
    CountClr = clr_req;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    drive(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    idle();
    check("rst_flags",    Flags,    4'b0000);
    check("rst_inshadow", InShadow, 1'b0);
    check("rst_regwrite", RegWrite, 1'b0);

    drive(0, 1, 0, 4'hE, 4'b0100, 2'b11, 0, 1, 0);
    check("al_regwrite", RegWrite, 1'b1);
    idle();
    check("al_flags", Flags, 4'b0100);

    drive(0, 1, 0, 4'h1, 4'h0, 2'b00, 0, 1, 1);
    check("ne_regwrite", RegWrite, 1'b0);
    check("ne_memwrite", MemWrite, 1'b0);
    drive(0, 1, 0, 4'h0, 4'h0, 2'b00, 0, 1, 1);
    check("eq_regwrite", RegWrite, 1'b1);
    check("eq_memwrite", MemWrite, 1'b1);
    check("eq_flags",    Flags,    4'b0100);

    drive(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    drive(0, 1, 0, 4'hE, 4'b1011, 2'b10, 0, 0, 0);
    idle();
    check("nz_only_flags", Flags, 4'b1000);

    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0);
    check("br_pcsrc", PCSrc, 1'b1);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    check("sh1_regwrite", RegWrite, 1'b0);
    check("sh1_inshadow", InShadow, 1'b1);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    check("sh2_regwrite", RegWrite, 1'b0);
    check("sh2_inshadow", InShadow, 1'b1);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    check("post_sh_regwrite", RegWrite, 1'b1);
    check("post_sh_inshadow", InShadow, 1'b0);

    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0);
    drive(1, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    check("rst_sh_inshadow", InShadow, 1'b1);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    check("after_rst_inshadow", InShadow, 1'b0);
    check("after_rst_flags",    Flags,    4'b0000);
    check("after_rst_regwrite", RegWrite, 1'b1);

    drive(1, 1, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0);
    check("rst_br_pcsrc", PCSrc, 1'b1);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    check("rst_br_noshadow", InShadow, 1'b0);

    drive(0, 1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1);
    check("flush_pcsrc",  PCSrc,  1'b0);
    check("flush_condex", CondEx, 1'b0);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    check("flush_noshadow", InShadow, 1'b0);
    check("flush_flags",    Flags,    4'b0000);

    drive(0, 1, 0, 4'hF, 4'hF, 2'b11, 0, 1, 0);
    check("nv_regwrite", RegWrite, 1'b0);
    idle();
    check("nv_flags", Flags, 4'b0000);

    drive(0, 1, 0, 4'hE, 4'b1001, 2'b11, 0, 0, 0);
    drive(0, 1, 0, 4'hA, 4'h0, 2'b00, 0, 1, 0);
    check("ge_regwrite", RegWrite, 1'b1);
    drive(0, 1, 0, 4'hB, 4'h0, 2'b00, 0, 1, 0);
    check("lt_regwrite", RegWrite, 1'b0);
    drive(0, 1, 0, 4'hC, 4'h0, 2'b00, 0, 1, 0);
    check("gt_regwrite", RegWrite, 1'b1);

    for (int f = 0; f < 16; f++) begin
      drive(0, 1, 0, 4'hE, 4'(f), 2'b11, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        drive(0, 1, 0, 4'(c), 4'(15 - f), 2'b00, 0, 1, 1);
      end
      idle();
    end

`ifdef COND_UNIT_PERF_EN
    clr_req = 1'b1;
    idle();
    clr_req = 1'b0;
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 1);
    drive(0, 1, 0, 4'hF, 4'h0, 2'b00, 0, 1, 0);
    drive(0, 1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    idle();
    check("perf_exec",   ExecCount,   32'd3);
    check("perf_squash", SquashCount, 32'd2);
    clr_req = 1'b1;
    drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    clr_req = 1'b0;
    idle();
    check("clr_exec",   ExecCount,   32'd0);
    check("clr_squash", SquashCount, 32'd0);
`endif

    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
